fifo_stream_drain: RTL
======================

// Module: fifo_stream_drain
//
// PURPOSE
//   Read-side stage directly downstream of the 16x8 synchronous FIFO.
//   - Drives the FIFO's read enable.
//   - Absorbs the FIFO's 1-cycle registered read latency.
//   - Re-presents the data as a valid/ready stream for the next consumer.
//   A 2-entry output buffer sustains 1 word/cycle with no bubbles and no
//   lost words under arbitrary m_ready backpressure.
//
// PARAMETERS
//   DATA_WIDTH  8  width of FIFO read data and stream data
//   BUF_DEPTH   2  output buffer entries; fixed, other values unsupported
//
// PORTS
//   clk          in   1           single clock; all state on posedge
//   rst          in   1           asynchronous, active-low reset (0 = reset)
//   fifo_empty   in   1           FIFO empty flag
//   fifo_r_en    out  1           FIFO read enable (one pop per high cycle)
//   fifo_r_data  in   DATA_WIDTH  FIFO read data, valid 1 cycle after fifo_r_en
//   m_valid      out  1           stream data valid
//   m_ready      in   1           stream consumer ready
//   m_data       out  DATA_WIDTH  stream data (buffer head)
//   buf_count    out  2           words held in the output buffer (0..2)
//
// BEHAVIOUR
//   Reset (rst=0, async assert, sync release):
//   - buf_count=0, rd_pend=0, m_valid=0, m_data=0, both buffer entries=0.
//   - fifo_r_en=0 while in reset.
//
//   Internal state:
//   - rd_pend: 1-bit flag, set on the cycle after fifo_r_en=1.
//   - buf0: buffer head; buf1: second entry.
//
//   Per-cycle signals:
//   - pop  = m_valid & m_ready
//   - push = rd_pend
//
//   Read issue (combinational):
//   - fifo_r_en = !fifo_empty & ((buf_count + rd_pend - pop) < 2)
//   - This gives a comb path m_ready -> fifo_r_en; it is required for full
//     throughput.
//   - Credit rule: buf_count + rd_pend never exceeds 2, so every in-flight
//     word has a free slot and the FIFO is never over-read.
//
//   Capture:
//   - When rd_pend=1, fifo_r_data is written into the buffer that edge.
//   - fifo_r_data is sampled only when rd_pend=1. A stale FIFO r_data value
//     must never enter the buffer.
//
//   Buffer update (FIFO order preserved):
//   - push only, count 0   -> buf0
//   - push only, count 1   -> buf1
//   - pop only             -> buf0<=buf1
//   - push+pop, count 1    -> buf0<=new
//   - push+pop, count 2    -> buf0<=buf1, buf1<=new
//   - push with count 2 and no pop cannot occur; assert on it.
//
//   Outputs:
//   - m_valid = (buf_count != 0); m_data = buf0; both registered-state driven.
//   - m_data is stable while m_valid=1 & m_ready=0 (AXI-style hold rule).
//     m_valid never drops without a pop.
//
//   Latency:
//   - fifo_empty falls in cycle N -> fifo_r_en=1 in N -> m_valid=1 in N+2.
//   - Sustained throughput is 1 word/cycle when m_ready=1 and the FIFO is
//     non-empty.
//
//   Boundary conditions:
//   - FIFO empties mid-burst: fifo_r_en drops the same cycle. Buffered words
//     still drain.
//   - m_ready low for many cycles: buffer fills to 2, then fifo_r_en=0.
//     No words lost.
//   - Reset mid-transfer: an in-flight word is discarded and the buffer is
//     cleared. The FIFO side is reset by its own controller.
//
// STRUCTURE
//   - Shared package fifo_stream_pkg:
//     - localparam BUF_DEPTH=2
//     - localparam CNT_W=2
//   - One natural sub-module: stream_buf2, the 2-entry ordered buffer.
//     - Inputs: push, push_data, pop.
//     - Outputs: head, count.
//   - Top level holds rd_pend and the issue/credit logic.
//
// TESTING
//   - Reset: hold rst=0 with fifo_empty=0 -> fifo_r_en=0, m_valid=0, m_data=0,
//     buf_count=0. Release rst -> fifo_r_en=1 on the next cycle.
//   - Single word: FIFO holds 8'hA5, m_ready=1 -> fifo_r_en pulses 1 cycle.
//     m_valid=1 with m_data=8'hA5 exactly 2 cycles later, for 1 cycle.
//   - Streaming: FIFO preloaded with 16 words 0x00..0x0F, m_ready=1 ->
//     16 consecutive m_valid cycles, data 0x00..0x0F in order, no gaps.
//   - Backpressure: 16 words, m_ready=0 for 10 cycles then 1 ->
//     buf_count reaches 2, exactly 2 pops issued, m_data holds 0x00.
//     All 16 words then delivered in order.
//   - Random m_ready (50%) with random FIFO writes over 1000 words ->
//     scoreboard in-order match, no drops/duplicates, buf_count+rd_pend<=2.
//   - Reset mid-burst with buf_count=2 and rd_pend=1 -> all outputs 0
//     immediately, no m_valid until new data is read.

Source files
------------

// File: rtl/fifo_stream_pkg.sv
// Shared constants for the FIFO read-side stream stage.
//   BUF_DEPTH : number of output buffer entries (fixed at 2)
//   CNT_W     : width of the buffer occupancy count (0..2)
package fifo_stream_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = 2;

endpackage

// File: rtl/fifo_stream_drain_buf2.sv
// stream_buf2: 2-entry ordered buffer. buf0 is the head, buf1 the second word.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push, push_data write a new word (appended behind any held words)
//   pop             remove the head word
//   head            current head word (buf0)
//   count           number of words held (0..2)
module stream_buf2
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [CNT_W-1:0]      r_count;

  // Ordered buffer update: a pop shifts buf1 forward, a push lands behind the
  // last held word so FIFO order is preserved.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf0  <= {DATA_WIDTH{1'b0}};
      r_buf1  <= {DATA_WIDTH{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      case ({push, pop})
        2'b10: begin
          if (r_count == CNT_W'(0)) begin
            r_buf0 <= push_data;
          end else begin
            r_buf1 <= push_data;
          end
          r_count <= r_count + CNT_W'(1);
        end
        2'b01: begin
          r_buf0  <= r_buf1;
          r_count <= r_count - CNT_W'(1);
        end
        2'b11: begin
          // Count is unchanged; with two held words the new word goes behind buf1.
          if (r_count == CNT_W'(2)) begin
            r_buf0 <= r_buf1;
            r_buf1 <= push_data;
          end else begin
            r_buf0 <= push_data;
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  assign head  = r_buf0;
  assign count = r_count;

endmodule

// File: rtl/fifo_stream_drain_chk.sv
// Checker for the output buffer: a push into a full buffer without a
// simultaneous pop would overwrite a held word and must never happen.
// Ports: clk, rst (active-low), push, pop, count (buffer occupancy).
module fifo_stream_drain_chk
  import fifo_stream_pkg::*;
(
  input logic             clk,
  input logic             rst,
  input logic             push,
  input logic             pop,
  input logic [CNT_W-1:0] count
);

  // Overfill check, sampled on every active edge outside reset.
  always @(posedge clk) begin
    if (rst) begin
      a_no_overfill: assert (!(push && !pop && (count == CNT_W'(BUF_DEPTH))));
    end
  end

endmodule

// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: read-side stage after a synchronous FIFO with 1-cycle
// registered read latency. Issues FIFO reads against buffer credit and
// re-presents the words as a valid/ready stream without bubbles.
// Ports:
//   clk          clock
//   rst          asynchronous active-low reset
//   fifo_empty   FIFO empty flag
//   fifo_r_en    FIFO read enable (one pop per high cycle)
//   fifo_r_data  FIFO read data, valid one cycle after fifo_r_en
//   m_valid      stream valid
//   m_ready      stream ready
//   m_data       stream data (buffer head)
//   buf_count    words held in the output buffer (0..2)
module fifo_stream_drain
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_W-1:0]      buf_count
);

  logic                  r_run;
  logic                  r_rd_pend;
  logic                  w_pop;
  logic [CNT_W:0]        w_credit;
  logic [CNT_W-1:0]      w_count;
  logic [DATA_WIDTH-1:0] w_head;

  // Reset release is taken on a clock edge, so reads start one cycle after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // A read issued this cycle delivers its word on the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= fifo_r_en;
    end
  end

  assign m_valid   = (w_count != CNT_W'(0));
  assign m_data    = w_head;
  assign buf_count = w_count;

  // Read issue: held words plus the in-flight word, less this cycle's pop,
  // must leave a free slot. Includes m_ready so a draining buffer keeps
  // reading back-to-back.
  always_comb begin
    w_pop    = m_valid & m_ready;
    w_credit = {1'b0, w_count} + {{CNT_W{1'b0}}, r_rd_pend} - {{CNT_W{1'b0}}, w_pop};
    if (r_run && !fifo_empty && (w_credit < (CNT_W+1)'(BUF_DEPTH))) begin
      fifo_r_en = 1'b1;
    end else begin
      fifo_r_en = 1'b0;
    end
  end

  // Only a pending read writes the buffer, so stale read data is never captured.
  stream_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (r_rd_pend),
    .push_data(fifo_r_data),
    .pop      (w_pop),
    .head     (w_head),
    .count    (w_count)
  );

  fifo_stream_drain_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (r_rd_pend),
    .pop  (w_pop),
    .count(w_count)
  );

endmodule
